// File: rtl/eva_axi_rd_arb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_axi_arb_pkg : shared types and constants for the EVA AXI read arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
package eva_axi_arb_pkg;

  localparam int MIDX_W = 2;
  localparam int DATA_W = 128;

  typedef struct packed {
    logic [31:0] addr;
    logic [5:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } ar_req_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/eva_axi_rd_arb_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_axi_rd_arb_if : upstream per-master bundle and downstream AXI read bus
// Rev 1.0
// ----------------------------------------------------------------------------
interface eva_arb_up_if #(parameter int NUM_M = 4);
  import eva_axi_arb_pkg::*;

  logic [NUM_M-1:0]    m_arvalid;
  logic [NUM_M-1:0]    m_arready;
  logic [NUM_M*2-1:0]  m_arid;
  logic [NUM_M*32-1:0] m_araddr;
  logic [NUM_M*6-1:0]  m_arlen;
  logic [NUM_M*3-1:0]  m_arsize;
  logic [NUM_M*2-1:0]  m_arburst;
  logic [NUM_M-1:0]    m_rvalid;
  logic [NUM_M-1:0]    m_rready;
  logic [1:0]          m_rid;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rlast;
  logic [1:0]          m_rresp;

  modport master (
    output m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    input  m_arready, m_rvalid, m_rid, m_rdata, m_rlast, m_rresp
  );

  modport slave (
    input  m_arvalid, m_arid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    output m_arready, m_rvalid, m_rid, m_rdata, m_rlast, m_rresp
  );
endinterface

interface eva_axi_rd_if;
  import eva_axi_arb_pkg::*;

  logic              arvalid;
  logic              arready;
  logic [3:0]        arid;
  logic [31:0]       araddr;
  logic [5:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [3:0]        rid;
  logic [DATA_W-1:0] rdata;
  logic              rlast;
  logic [1:0]        rresp;

  modport master (
    output arvalid, arid, araddr, arlen, arsize, arburst, rready,
    input  arready, rvalid, rid, rdata, rlast, rresp
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, arsize, arburst, rready,
    output arready, rvalid, rid, rdata, rlast, rresp
  );
endinterface
`default_nettype wire

// File: rtl/eva_axi_rd_arb_rr_pick.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_rr_pick : combinational round-robin picker starting at ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module eva_rr_pick
  import eva_axi_arb_pkg::*;
#(
  parameter int NUM_M = 4
) (
  input  logic [NUM_M-1:0]  req,
  input  logic [MIDX_W-1:0] ptr,
  output logic              gnt_valid,
  output logic [MIDX_W-1:0] gnt_idx
);

  localparam logic [MIDX_W:0] NUM_M_W = NUM_M[MIDX_W:0];

  logic [MIDX_W:0] pos;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    pos       = '0;
    // Scan farthest-first so the candidate nearest to ptr is written last and wins.
    for (int k = NUM_M - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + k[MIDX_W:0];
      if (pos >= NUM_M_W) begin
        pos = pos - NUM_M_W;
      end
      if (req[pos[MIDX_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = pos[MIDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/eva_axi_rd_arb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// eva_axi_rd_arb : round-robin AR arbiter with rid-based R steering
// Rev 1.0
// ----------------------------------------------------------------------------
module eva_axi_rd_arb
  import eva_axi_arb_pkg::*;
#(
  parameter int NUM_M   = 4,
  parameter int MAX_OUT = 4
) (
  input  logic          aclk,
  input  logic          arest_n,
  eva_arb_up_if.slave   up,
  eva_axi_rd_if.master  dn,
  output logic          err_rid
);

  localparam logic [3:0]        MAX_OUT_C = MAX_OUT[3:0];
  localparam logic [MIDX_W-1:0] LAST_IDX  = MIDX_W'(NUM_M - 1);

  arb_state_e              state;
  arb_state_e              state_nxt;
  logic [MIDX_W-1:0]       rr_ptr;
  logic [MIDX_W-1:0]       rr_ptr_nxt;
  ar_req_t                 ar_q;
  ar_req_t                 ar_nxt;
  logic [NUM_M-1:0][3:0]   cnt;
  logic [NUM_M-1:0]        elig;
  logic [NUM_M-1:0]        arready_m;
  logic [NUM_M-1:0]        ar_hs;
  logic [NUM_M-1:0]        rl_hs;
  logic                    gnt_valid;
  logic [MIDX_W-1:0]       gnt_idx;
  logic [MIDX_W-1:0]       rsel;
  logic                    rid_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_M; gi++) begin : g_elig
      assign elig[gi] = up.m_arvalid[gi] & (cnt[gi] < MAX_OUT_C);
    end
  endgenerate

  eva_rr_pick #(.NUM_M(NUM_M)) u_pick (
    .req       (elig),
    .ptr       (rr_ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    ar_nxt     = ar_q;
    arready_m  = '0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          arready_m[gnt_idx] = 1'b1;
          ar_nxt.addr  = up.m_araddr[32*gnt_idx +: 32];
          ar_nxt.len   = up.m_arlen[6*gnt_idx +: 6];
          ar_nxt.size  = up.m_arsize[3*gnt_idx +: 3];
          ar_nxt.burst = up.m_arburst[2*gnt_idx +: 2];
          ar_nxt.id    = {gnt_idx, up.m_arid[2*gnt_idx +: 2]};
          rr_ptr_nxt   = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (dn.arready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A rid whose master index is out of range is absorbed so the bus never stalls.
  always_comb begin
    rsel        = dn.rid[3:2];
    rid_ok      = 1'b0;
    dn.rready   = 1'b1;
    up.m_rvalid = '0;
    rl_hs       = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (rsel == MIDX_W'(i)) begin
        rid_ok         = 1'b1;
        dn.rready      = up.m_rready[i];
        up.m_rvalid[i] = dn.rvalid;
        rl_hs[i]       = dn.rvalid & up.m_rready[i] & dn.rlast;
      end
    end
  end

  assign ar_hs = up.m_arvalid & arready_m;

  always_ff @(posedge aclk or negedge arest_n) begin
    if (!arest_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      ar_q    <= '0;
      cnt     <= '0;
      err_rid <= 1'b0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      ar_q   <= ar_nxt;
      if (dn.rvalid && !rid_ok) begin
        err_rid <= 1'b1;
      end
      for (int i = 0; i < NUM_M; i++) begin
        if (ar_hs[i] && !rl_hs[i]) begin
          cnt[i] <= cnt[i] + 4'd1;
        end else if (!ar_hs[i] && rl_hs[i] && (cnt[i] != 4'd0)) begin
          cnt[i] <= cnt[i] - 4'd1;
        end
      end
    end
  end

  assign up.m_arready = arready_m;
  assign dn.arvalid   = (state == HOLD);
  assign dn.arid      = ar_q.id;
  assign dn.araddr    = ar_q.addr;
  assign dn.arlen     = ar_q.len;
  assign dn.arsize    = ar_q.size;
  assign dn.arburst   = ar_q.burst;
  assign up.m_rid     = dn.rid[1:0];
  assign up.m_rdata   = dn.rdata;
  assign up.m_rlast   = dn.rlast;
  assign up.m_rresp   = dn.rresp;

endmodule
`default_nettype wire

// File: doc/eva_axi_rd_arb.md
Name: eva_axi_rd_arb

Overview:
Round-robin arbiter that shares the single 128-bit EVA AXI read port (4-bit ID, 6-bit len) among up to four internal read masters. Each AR request is registered in a one-entry holding stage and tagged with the winning master's index in arid[3:2]. R beats are steered back to the owning master by rid[3:2]. Per-master outstanding-burst counters throttle any master that reaches MAX_OUT.

Parameters:
NUM_M, 4, number of read masters (1..4)
MAX_OUT, 4, max outstanding bursts per master (1..15)

Ports:
aclk  in  1  clock
arest_n  in  1  asynchronous active-low reset
m_arvalid  in  NUM_M  per-master AR valid
m_arready  out  NUM_M  per-master AR ready
m_arid  in  NUM_M*2  per-master 2-bit ID, master i at [2i+1:2i]
m_araddr  in  NUM_M*32  per-master address
m_arlen  in  NUM_M*6  per-master burst length
m_arsize  in  NUM_M*3  per-master size
m_arburst  in  NUM_M*2  per-master burst type
m_rvalid  out  NUM_M  per-master R valid
m_rready  in  NUM_M  per-master R ready
m_rid  out  2  R ID to masters, = rid[1:0]
m_rdata  out  128  R data, broadcast to all masters
m_rlast  out  1  R last, broadcast
m_rresp  out  2  R resp, broadcast
arvalid / arready  out / in  1 / 1  downstream AR handshake
arid  out  4  {master index[1:0], m_arid[1:0]}
araddr / arlen / arsize / arburst  out  32/6/3/2  registered AR fields
rvalid / rready  in / out  1 / 1  downstream R handshake
rid / rdata / rlast / rresp  in  4/128/1/2  downstream R fields
err_rid  out  1  sticky: R beat carried rid[3:2] >= NUM_M

Behaviour:
- Clock and reset: one clock, aclk. Reset arest_n is asynchronous and active-low.
- Reset values: FSM=IDLE; arvalid=0; all AR field registers=0; rr_ptr=0; all outstanding counters=0; err_rid=0; m_arready=0.
- FSM, state IDLE:
  - Eligible master i: m_arvalid[i] & (cnt[i] < MAX_OUT).
  - Winner: first eligible master scanning from rr_ptr upward, modulo NUM_M.
  - If a winner exists: m_arready[winner]=1 (combinational, IDLE only); capture its fields and arid={winner, m_arid}; rr_ptr <= (winner+1) mod NUM_M; go to HOLD.
  - If no winner: all m_arready=0; stay in IDLE.
- FSM, state HOLD:
  - arvalid=1; fields stable.
  - On arready=1: arvalid <= 0; go to IDLE.
  - m_arready is all zero in HOLD.
- Latency and throughput: master handshake at cycle t gives arvalid=1 at t+1. Peak rate is one AR per 2 cycles.
- Outstanding counter cnt[i], width 4:
  - +1 on m_arvalid[i]&m_arready[i].
  - -1 on rvalid&rready&rlast with rid[3:2]==i.
  - Both in the same cycle: unchanged.
  - Never wraps: a counter at MAX_OUT makes the master ineligible.
- R routing (combinational, no added latency):
  - m_rvalid[i] = rvalid & (rid[3:2]==i).
  - rready = m_rready[rid[3:2]] when rid[3:2] < NUM_M.
  - If rid[3:2] >= NUM_M: rready=1 (beat dropped); err_rid <= 1 on rvalid; err_rid clears only on reset.
- Unused master slots (NUM_M < 4) are never granted.
- Reset mid-burst: all state clears immediately and outstanding bursts are forgotten. Upstream and downstream logic are reset together.

Decomposition:
- Package eva_axi_arb_pkg:
  - typedef ar_req_t struct {addr[31:0], len[5:0], size[2:0], burst[1:0], id[3:0]}
  - typedef enum arb_state_e {IDLE, HOLD}
  - constants MIDX_W=2, DATA_W=128
- Sub-module eva_rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_M], ptr.
  - Outputs: gnt_valid, gnt_idx.

Test Plan:
- Single master: m_arvalid[0]=1, addr 0x1000, len 3, id 2. Required: arvalid at t+1, araddr=0x1000, arid=4'b0010. Four R beats with rid=2 appear only on m_rvalid[0]; cnt[0] returns to 0 after rlast.
- Fairness: masters 0-3 all hold valid continuously, arready=1. Required grant order 0,1,2,3,0, one grant per 2 cycles; arid[3:2] follows 0,1,2,3,0.
- Backpressure: arready=0 for 5 cycles in HOLD. Required: arvalid and all fields stable, m_arready all 0, no second grant until arready=1.
- Throttle: MAX_OUT=2, master 1 issues 2 bursts with no R returned. Required: third request not granted while master 2 is still served. rlast for rid=4'b01xx re-enables master 1 on the next IDLE cycle.
- Simultaneous events: master 0 grant in the same cycle as its rlast handshake. Required: cnt[0] unchanged. Separately, rid=4'b1100 with NUM_M=3 gives rready=1, err_rid=1, no m_rvalid asserted.
- Reset mid-HOLD: assert arest_n=0 asynchronously. Required: arvalid, err_rid and counters drop to 0 immediately. After release the first grant goes to master 0.
